// File: rtl/imem_byte_loader_if.sv
// Byte-stream and RAM-write bundle between the program host and the loader.
// master = host driving the byte stream, slave = the loader itself.
interface imem_byte_loader_if #(
  parameter int ADDR_W = 4
);
  logic              load_req;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              chk_err;

  modport master (
    output load_req,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  cpu_hold,
    input  done,
    input  chk_err
  );

  modport slave (
    input  load_req,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output cpu_hold,
    output done,
    output chk_err
  );
endinterface

// File: rtl/imem_byte_loader.sv
// imem_byte_loader: byte-serial writer for the MIPS16 instruction RAM.
// Optional trailer-byte XOR check: define IMEM_LOADER_CHECKSUM_EN.
module imem_byte_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input logic               clk,
  input logic               rst,
  imem_byte_loader_if.slave bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, RX_HI, RX_LO, WRITE, CHK, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RX_HI, RX_LO, WRITE, DONE
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(WORDS - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi;
  logic [7:0]        lo;
  logic              ready;
  logic              xfer;
  logic              start;
  logic              chk_err_q;

  // Outputs decode from the state register only.
  always_comb begin
    ready = 1'b0;
    unique case (state)
      RX_HI:   ready = 1'b1;
      RX_LO:   ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:     ready = 1'b1;
`endif
      default: ready = 1'b0;
    endcase
  end

  assign xfer  = bus.byte_valid & ready;
  assign start = (state == IDLE) & bus.load_req;

  assign bus.byte_ready = ready;
  assign bus.wr_en      = (state == WRITE);
  assign bus.wr_addr    = addr;
  assign bus.wr_data    = {hi, lo};
  assign bus.cpu_hold   = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.chk_err    = chk_err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (bus.load_req) state_nx = RX_HI;
      RX_HI:
        if (xfer) state_nx = RX_LO;
      RX_LO:
        if (xfer) state_nx = WRITE;
      WRITE:
        if (addr == LAST) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = CHK;
`else
          state_nx = DONE;
`endif
        end else begin
          state_nx = RX_HI;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:
        if (xfer) state_nx = DONE;
`endif
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // addr saturates at LAST; the FSM leaves WRITE before it could wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (start)
        addr <= '0;
      if (state == WRITE && addr != LAST)
        addr <= addr + ADDR_W'(1);
      if (state == RX_HI && xfer)
        hi <= bus.byte_in;
      if (state == RX_LO && xfer)
        lo <= bus.byte_in;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       data_xfer;

  assign data_xfer = xfer & (state != CHK);

  // chk_err stays set until the next accepted load_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum      <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (start) begin
        csum      <= '0;
        chk_err_q <= 1'b0;
      end
      if (data_xfer)
        csum <= csum ^ bus.byte_in;
      if (state == CHK && xfer)
        chk_err_q <= (bus.byte_in != csum);
    end
  end
`else
  assign chk_err_q = 1'b0;
`endif

endmodule

// File: tb/tb_imem_byte_loader.sv
// Directed bench for imem_byte_loader: full load, stalls, reset, edges.
// Second instance covers the WORDS=2 / ADDR_W=1 minimum build.
`timescale 1ns/1ps
module tb_imem_byte_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int DONE_LAT = 1;
`else
  localparam int DONE_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_byte_loader_if #(.ADDR_W(4)) bi();
  imem_byte_loader_if #(.ADDR_W(1)) bs();

  imem_byte_loader #(.WORDS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bi)
  );
  imem_byte_loader #(.WORDS(2), .ADDR_W(1)) dut_min (
    .clk(clk), .rst(rst), .bus(bs)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [3:0]  w_addr[$];
  logic [15:0] w_data[$];
  logic [0:0]  s_addr[$];
  logic [15:0] s_data[$];
  int n_done, done_cyc, last_xfer, bad_timing;
  int hold_drop, drop_cyc, nbytes, s_done;
  bit prev_lo, prev_hold;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bi.wr_en) begin
      w_addr.push_back(bi.wr_addr);
      w_data.push_back(bi.wr_data);
      if (!prev_lo) bad_timing++;
    end
    if (bi.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (prev_hold && !bi.cpu_hold) begin
      hold_drop++;
      drop_cyc = cyc;
    end
    prev_hold = bi.cpu_hold;
    prev_lo = 1'b0;
    if (bi.byte_valid && bi.byte_ready) begin
      nbytes++;
      last_xfer = cyc;
      prev_lo = (nbytes % 2 == 0);
    end
    if (bs.wr_en) begin
      s_addr.push_back(bs.wr_addr);
      s_data.push_back(bs.wr_data);
    end
    if (bs.done) s_done++;
  end

  function automatic logic [7:0] hi_b(int k);
    return 8'h01 + 8'(k * 17);
  endfunction

  function automatic logic [7:0] lo_b(int k);
    return hi_b(k) + 8'h22;
  endfunction

  function automatic logic [7:0] csum_all();
    logic [7:0] c = 8'h00;
    for (int k = 0; k < 16; k++) c = c ^ hi_b(k) ^ lo_b(k);
    return c;
  endfunction

  task automatic clear_mon();
    w_addr.delete();
    w_data.delete();
    s_addr.delete();
    s_data.delete();
    n_done = 0; bad_timing = 0; hold_drop = 0;
    nbytes = 0; s_done = 0; done_cyc = -1; drop_cyc = -1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    bi.byte_in = b;
    bi.byte_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bi.byte_ready) begin
        got = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bi.byte_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte: byte_ready stayed 0, required 1");
    end
  endtask

  task automatic send_byte_s(input logic [7:0] b);
    bit got = 1'b0;
    bs.byte_in = b;
    bs.byte_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bs.byte_ready) begin
        got = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bs.byte_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_s: byte_ready stayed 0, required 1");
    end
  endtask

  task automatic start_load();
    bi.load_req = 1'b1;
    @(posedge clk);
    #1;
    bi.load_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && n_done == 0; i++) @(negedge clk);
    if (n_done == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: done never pulsed, required 1 pulse");
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(int gapmax);
    for (int k = 0; k < 16; k++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send_byte(hi_b(k));
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send_byte(lo_b(k));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum_all());
`endif
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bi.load_req = 1'b1;
    bi.byte_valid = 1'b1;
    bi.byte_in = 8'h55;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bi.byte_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_ready: got %b need 0", bi.byte_ready);
    end
    n_cmp++;
    if (bi.wr_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_wr_en: got %b need 0", bi.wr_en);
    end
    n_cmp++;
    if (bi.wr_addr !== 4'h0) begin
      n_bad++; $display("FAIL rst_wr_addr: got %h need 0", bi.wr_addr);
    end
    n_cmp++;
    if (bi.wr_data !== 16'h0000) begin
      n_bad++; $display("FAIL rst_wr_data: got %h need 0", bi.wr_data);
    end
    n_cmp++;
    if (bi.cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL rst_hold: got %b need 0", bi.cpu_hold);
    end
    n_cmp++;
    if (bi.done !== 1'b0) begin
      n_bad++; $display("FAIL rst_done: got %b need 0", bi.done);
    end
    n_cmp++;
    if (bi.chk_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_chk_err: got %b need 0", bi.chk_err);
    end
    n_cmp++;
    if (bs.cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL rst_min_hold: got %b need 0", bs.cpu_hold);
    end
    @(posedge clk);
    #1;
    bi.load_req = 1'b0;
    bi.byte_valid = 1'b0;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_full_load();
    clear_mon();
    start_load();
    @(negedge clk);
    n_cmp++;
    if (bi.cpu_hold !== 1'b1) begin
      n_bad++; $display("FAIL full_hold_rise: got %b need 1", bi.cpu_hold);
    end
    @(posedge clk);
    #1;
    load_words(0);
    wait_done();
    n_cmp++;
    if (w_addr.size() != 16) begin
      n_bad++; $display("FAIL full_count: got %0d need 16", w_addr.size());
    end
    for (int k = 0; k < 16 && k < w_addr.size(); k++) begin
      n_cmp++;
      if (w_addr[k] !== 4'(k) || w_data[k] !== {hi_b(k), lo_b(k)}) begin
        n_bad++;
        $display("FAIL full_word%0d: got %h/%h need %h/%h", k,
                 w_addr[k], w_data[k], 4'(k), {hi_b(k), lo_b(k)});
      end
    end
    n_cmp++;
    if (w_data.size() == 16 &&
        (w_data[0] !== 16'h0123 || w_data[1] !== 16'h1234 ||
         w_data[15] !== 16'h0022)) begin
      n_bad++; $display("FAIL full_const: got %h %h %h need 0123 1234 0022",
                        w_data[0], w_data[1], w_data[15]);
    end
    n_cmp++;
    if (bad_timing !== 0) begin
      n_bad++; $display("FAIL full_wr_timing: got %0d stray need 0", bad_timing);
    end
    n_cmp++;
    if (n_done !== 1 || done_cyc !== last_xfer + DONE_LAT) begin
      n_bad++; $display("FAIL full_done: got %0d at %0d need 1 at %0d",
                        n_done, done_cyc, last_xfer + DONE_LAT);
    end
    n_cmp++;
    if (hold_drop !== 1 || drop_cyc !== done_cyc + 1) begin
      n_bad++; $display("FAIL full_hold_fall: got %0d at %0d need 1 at %0d",
                        hold_drop, drop_cyc, done_cyc + 1);
    end
    n_cmp++;
    if (bi.chk_err !== 1'b0) begin
      n_bad++; $display("FAIL full_chk_err: got %b need 0", bi.chk_err);
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    start_load();
    load_words(5);
    wait_done();
    n_cmp++;
    if (w_addr.size() != 16) begin
      n_bad++; $display("FAIL bp_count: got %0d need 16", w_addr.size());
    end
    for (int k = 0; k < 16 && k < w_addr.size(); k++) begin
      n_cmp++;
      if (w_addr[k] !== 4'(k) || w_data[k] !== {hi_b(k), lo_b(k)}) begin
        n_bad++;
        $display("FAIL bp_word%0d: got %h/%h need %h/%h", k,
                 w_addr[k], w_data[k], 4'(k), {hi_b(k), lo_b(k)});
      end
    end
    n_cmp++;
    if (bad_timing !== 0) begin
      n_bad++; $display("FAIL bp_wr_timing: got %0d stray need 0", bad_timing);
    end
    n_cmp++;
    if (n_done !== 1) begin
      n_bad++; $display("FAIL bp_done: got %0d need 1", n_done);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_load();
    for (int i = 0; i < 5; i++)
      send_byte(i[0] ? lo_b(i / 2) : hi_b(i / 2));
    idle(1);
    n_cmp++;
    if (w_addr.size() != 2) begin
      n_bad++; $display("FAIL mid_pre_count: got %0d need 2", w_addr.size());
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bi.cpu_hold !== 1'b0 || bi.byte_ready !== 1'b0 ||
        bi.wr_en !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_out: got hold=%b rdy=%b wr=%b need 0 0 0",
                        bi.cpu_hold, bi.byte_ready, bi.wr_en);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    start_load();
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (w_addr.size() != 1 || w_addr[0] !== 4'h0 ||
        w_data[0] !== 16'hABCD) begin
      n_bad++; $display("FAIL mid_reload: got n=%0d %h/%h need 1 0/abcd",
                        w_addr.size(), w_addr[0], w_data[0]);
    end
    @(posedge clk);
    #1;
    pulse_rst();
  endtask

  task automatic test_protocol();
    clear_mon();
    bi.byte_in = 8'hAA;
    bi.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bi.byte_ready !== 1'b0) begin
        n_bad++; $display("FAIL idle_ready: got %b need 0", bi.byte_ready);
      end
    end
    @(posedge clk);
    #1;
    bi.byte_valid = 1'b0;
    n_cmp++;
    if (w_addr.size() != 0 || bi.cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL idle_nowrite: got n=%0d hold=%b need 0 0",
                        w_addr.size(), bi.cpu_hold);
    end
    start_load();
    for (int k = 0; k < 16; k++) begin
      if (k == 5) start_load();
      if (k == 15) bi.load_req = 1'b1;
      send_byte(hi_b(k));
      send_byte(lo_b(k));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum_all());
`endif
    for (int i = 0; i < 40 && n_done == 0; i++) @(negedge clk);
    for (int i = 0; i < 4 && cyc < done_cyc + 1; i++) @(negedge clk);
    n_cmp++;
    if (n_done !== 1 || bi.cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL held_idle: got done=%0d hold=%b need 1 0",
                        n_done, bi.cpu_hold);
    end
    @(negedge clk);
    n_cmp++;
    if (bi.cpu_hold !== 1'b1 || bi.byte_ready !== 1'b1) begin
      n_bad++; $display("FAIL held_restart: got hold=%b rdy=%b need 1 1",
                        bi.cpu_hold, bi.byte_ready);
    end
    @(posedge clk);
    #1;
    bi.load_req = 1'b0;
    n_cmp++;
    if (w_addr.size() != 16) begin
      n_bad++; $display("FAIL midreq_count: got %0d need 16", w_addr.size());
    end
    for (int k = 0; k < 16 && k < w_addr.size(); k++) begin
      n_cmp++;
      if (w_addr[k] !== 4'(k) || w_data[k] !== {hi_b(k), lo_b(k)}) begin
        n_bad++;
        $display("FAIL midreq_word%0d: got %h/%h need %h/%h", k,
                 w_addr[k], w_data[k], 4'(k), {hi_b(k), lo_b(k)});
      end
    end
    pulse_rst();
  endtask

  task automatic test_checksum();
    clear_mon();
    start_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 0; k < 16; k++) begin
      send_byte(hi_b(k));
      send_byte(lo_b(k));
    end
    send_byte(csum_all() ^ 8'h5A);
    wait_done();
    idle(3);
    n_cmp++;
    if (bi.chk_err !== 1'b1 || n_done !== 1) begin
      n_bad++; $display("FAIL chk_bad: got err=%b done=%0d need 1 1",
                        bi.chk_err, n_done);
    end
    start_load();
    @(negedge clk);
    n_cmp++;
    if (bi.chk_err !== 1'b0) begin
      n_bad++; $display("FAIL chk_clear: got %b need 0", bi.chk_err);
    end
    @(posedge clk);
    #1;
`else
    send_byte(8'hFF);
    send_byte(8'h00);
    idle(2);
    n_cmp++;
    if (bi.chk_err !== 1'b0) begin
      n_bad++; $display("FAIL chk_tied: got %b need 0", bi.chk_err);
    end
`endif
    pulse_rst();
  endtask

  task automatic test_min_size();
    clear_mon();
    bs.load_req = 1'b1;
    @(posedge clk);
    #1;
    bs.load_req = 1'b0;
    send_byte_s(8'h5A);
    send_byte_s(8'hA5);
    send_byte_s(8'hC3);
    send_byte_s(8'h3C);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte_s(8'h00);
`endif
    for (int i = 0; i < 40 && s_done == 0; i++) @(negedge clk);
    idle(6);
    n_cmp++;
    if (s_addr.size() != 2 || s_done !== 1) begin
      n_bad++; $display("FAIL min_count: got n=%0d done=%0d need 2 1",
                        s_addr.size(), s_done);
    end
    n_cmp++;
    if (s_addr.size() == 2 &&
        (s_addr[0] !== 1'b0 || s_data[0] !== 16'h5AA5 ||
         s_addr[1] !== 1'b1 || s_data[1] !== 16'hC33C)) begin
      n_bad++; $display("FAIL min_words: got %h/%h %h/%h need 0/5aa5 1/c33c",
                        s_addr[0], s_data[0], s_addr[1], s_data[1]);
    end
    n_cmp++;
    if (bs.cpu_hold !== 1'b0) begin
      n_bad++; $display("FAIL min_hold: got %b need 0", bs.cpu_hold);
    end
  endtask

  initial begin
    bi.load_req = 1'b0;
    bi.byte_in = 8'h00;
    bi.byte_valid = 1'b0;
    bs.load_req = 1'b0;
    bs.byte_in = 8'h00;
    bs.byte_valid = 1'b0;
    clear_mon();
    #1;
    test_reset();
    test_full_load();
    test_backpressure();
    test_reset_mid();
    test_protocol();
    test_checksum();
    test_min_size();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still going, required finish");
    $fatal(1);
  end

endmodule
